// File: rtl/i281_trace_buffer_if.sv
// i281_trace_buffer_if: readout stream of the i281 trace buffer.
// master = trace buffer (produces entries), slave = consumer (starts and drains readout).
interface i281_trace_buffer_if #(
   parameter int ENTRY_W = 62
);
   logic               rd_start;
   logic               rd_ready;
   logic               rd_valid;
   logic [ENTRY_W-1:0] rd_data;
   logic               rd_last;

   modport master (
      input  rd_start,
      input  rd_ready,
      output rd_valid,
      output rd_data,
      output rd_last
   );

   modport slave (
      output rd_start,
      output rd_ready,
      input  rd_valid,
      input  rd_data,
      input  rd_last
   );
endinterface

// File: rtl/i281_trace_buffer.sv
// i281_trace_buffer: on-chip execution-trace capture for the i281 CPU.
// Records {cycle,instr,state,regs,flags} snapshots into a circular buffer, freezes
// POST_TRIG entries after a trigger and then streams the buffer out oldest-first.
// Optional feature: define I281_TRACE_DELTA_EN to skip writes whose snapshot repeats
// the last written one (first write after arm and the trigger entry are always kept).
//
// state    | meaning
// IDLE     | nothing pending, waiting for arm
// ARMED    | recording every capture_en cycle, watching for the trigger
// POST     | recording, post_cnt entries still to go after the trigger
// DONE     | capture frozen, waiting for rd_start
// READOUT  | streaming entries oldest-first over the rd port
module i281_trace_buffer #(
   parameter int DEPTH     = 64,
   parameter int NUM_REGS  = 4,
   parameter int REG_W     = 8,
   parameter int INSTR_W   = 5,
   parameter int STATE_W   = 5,
   parameter int FLAG_W    = 4,
   parameter int CYC_W     = 16,
   parameter int POST_TRIG = 8
) (
   input  logic                      clock,
   input  logic                      reset_n,
   input  logic                      capture_en,
   input  logic [INSTR_W-1:0]        instr,
   input  logic [STATE_W-1:0]        state,
   input  logic [NUM_REGS*REG_W-1:0] regs,
   input  logic [FLAG_W-1:0]         flags,
   input  logic                      arm,
   input  logic                      trig_en,
   input  logic [INSTR_W-1:0]        trig_instr,
   input  logic [STATE_W-1:0]        trig_state,
   output logic                      busy,
   output logic                      done,
   output logic                      wrapped,
   i281_trace_buffer_if.master       rd
);

   localparam int AW      = $clog2(DEPTH);
   localparam int FW      = AW + 1;
   localparam int SNAP_W  = INSTR_W + STATE_W + NUM_REGS*REG_W + FLAG_W;
   localparam int ENTRY_W = CYC_W + SNAP_W;
   localparam logic [FW-1:0] FILL_FULL = FW'(DEPTH);

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_ARMED,
      ST_POST,
      ST_DONE,
      ST_READOUT
   } state_e;

   state_e             state_q, state_d;
   logic [AW-1:0]      wr_ptr_q, wr_ptr_d;
   logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
   logic [AW-1:0]      post_cnt_q, post_cnt_d;
   logic [FW-1:0]      fill_q, fill_d;
   logic [FW-1:0]      remaining_q, remaining_d;
   logic               wrapped_q, wrapped_d;
   logic [CYC_W-1:0]   cyc_q, cyc_d;
   logic               rd_valid_q, rd_valid_d;
   logic               rd_last_q, rd_last_d;
   logic [ENTRY_W-1:0] rd_data_q, rd_data_d;

   logic [ENTRY_W-1:0] mem_q [DEPTH];

   logic [SNAP_W-1:0]  snap;
   logic [AW-1:0]      rd_start_ptr;
   logic               trig_hit;
   logic               wr_en;
   logic               suppress;

   assign snap         = {instr, state, regs, flags};
   assign rd_start_ptr = wrapped_q ? wr_ptr_q : '0;

   // Next-state, write qualification and readout sequencing; arm overrides everything.
   always_comb begin
      state_d     = state_q;
      wr_ptr_d    = wr_ptr_q;
      rd_ptr_d    = rd_ptr_q;
      post_cnt_d  = post_cnt_q;
      fill_d      = fill_q;
      remaining_d = remaining_q;
      wrapped_d   = wrapped_q;
      cyc_d       = cyc_q;
      rd_valid_d  = rd_valid_q;
      rd_last_d   = rd_last_q;
      rd_data_d   = rd_data_q;
      trig_hit    = 1'b0;
      wr_en       = 1'b0;

      if (arm) begin
         state_d     = ST_ARMED;
         wr_ptr_d    = '0;
         rd_ptr_d    = '0;
         post_cnt_d  = '0;
         fill_d      = '0;
         remaining_d = '0;
         wrapped_d   = 1'b0;
         cyc_d       = '0;
         rd_valid_d  = 1'b0;
         rd_last_d   = 1'b0;
      end else begin
         unique case (state_q)
            ST_IDLE: begin
            end

            ST_ARMED, ST_POST: begin
               cyc_d = cyc_q + CYC_W'(1);
               if (capture_en) begin
                  trig_hit = (state_q == ST_ARMED) && trig_en &&
                             (instr == trig_instr) && (state == trig_state);
                  // the trigger entry is kept even when it repeats the previous snapshot
                  wr_en    = trig_hit || !suppress;
               end
               if (wr_en) begin
                  wr_ptr_d = wr_ptr_q + AW'(1);
                  if (fill_q == FILL_FULL) begin
                     wrapped_d = 1'b1;
                  end else begin
                     fill_d = fill_q + FW'(1);
                  end
               end
               if (trig_hit) begin
                  post_cnt_d = AW'(POST_TRIG);
                  state_d    = (POST_TRIG == 0) ? ST_DONE : ST_POST;
               end else if ((state_q == ST_POST) && wr_en) begin
                  post_cnt_d = post_cnt_q - AW'(1);
                  if (post_cnt_q == AW'(1)) begin
                     state_d = ST_DONE;
                  end
               end
            end

            ST_DONE: begin
               if (rd.rd_start) begin
                  if (fill_q == '0) begin
                     state_d = ST_IDLE;
                  end else begin
                     state_d     = ST_READOUT;
                     rd_data_d   = mem_q[rd_start_ptr];
                     rd_valid_d  = 1'b1;
                     rd_last_d   = (fill_q == FW'(1));
                     rd_ptr_d    = rd_start_ptr + AW'(1);
                     remaining_d = fill_q - FW'(1);
                  end
               end
            end

            ST_READOUT: begin
               if (rd_valid_q && rd.rd_ready) begin
                  if (rd_last_q) begin
                     rd_valid_d = 1'b0;
                     rd_last_d  = 1'b0;
                     state_d    = ST_IDLE;
                  end else begin
                     // remaining counts entries not yet presented
                     rd_data_d   = mem_q[rd_ptr_q];
                     rd_ptr_d    = rd_ptr_q + AW'(1);
                     remaining_d = remaining_q - FW'(1);
                     rd_last_d   = (remaining_q == FW'(1));
                  end
               end
            end

            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end
   end

   // Control and readout registers.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         state_q     <= ST_IDLE;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         post_cnt_q  <= '0;
         fill_q      <= '0;
         remaining_q <= '0;
         wrapped_q   <= 1'b0;
         cyc_q       <= '0;
         rd_valid_q  <= 1'b0;
         rd_last_q   <= 1'b0;
         rd_data_q   <= '0;
      end else begin
         state_q     <= state_d;
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         post_cnt_q  <= post_cnt_d;
         fill_q      <= fill_d;
         remaining_q <= remaining_d;
         wrapped_q   <= wrapped_d;
         cyc_q       <= cyc_d;
         rd_valid_q  <= rd_valid_d;
         rd_last_q   <= rd_last_d;
         rd_data_q   <= rd_data_d;
      end
   end

   // Trace storage; no reset, locations are only read after being written.
   always_ff @(posedge clock) begin
      if (wr_en) begin
         mem_q[wr_ptr_q] <= {cyc_q, snap};
      end
   end

`ifdef I281_TRACE_DELTA_EN
   logic [SNAP_W-1:0] last_q, last_d;
   logic              first_q, first_d;

   // Track the last written snapshot; arm reopens the window for an unconditional first write.
   always_comb begin
      last_d  = last_q;
      first_d = first_q;
      if (arm) begin
         last_d  = '0;
         first_d = 1'b1;
      end else if (wr_en) begin
         last_d  = snap;
         first_d = 1'b0;
      end
   end

   // Compare register.
   always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
         last_q  <= '0;
         first_q <= 1'b1;
      end else begin
         last_q  <= last_d;
         first_q <= first_d;
      end
   end

   assign suppress = !first_q && (snap == last_q);
`else
   assign suppress = 1'b0;
`endif

   assign busy        = (state_q == ST_ARMED) || (state_q == ST_POST);
   assign done        = (state_q == ST_DONE);
   assign wrapped     = wrapped_q;
   assign rd.rd_valid = rd_valid_q;
   assign rd.rd_data  = rd_data_q;
   assign rd.rd_last  = rd_last_q;

endmodule

// File: tb/tb_i281_trace_buffer.sv
// tb_i281_trace_buffer: directed sequence with randomized CPU snapshots, checked against
// a queue-based model of what the trace buffer should have recorded.
module tb_i281_trace_buffer;

   localparam int DEPTH     = 64;
   localparam int NUM_REGS  = 4;
   localparam int REG_W     = 8;
   localparam int INSTR_W   = 5;
   localparam int STATE_W   = 5;
   localparam int FLAG_W    = 4;
   localparam int CYC_W     = 16;
   localparam int POST_TRIG = 8;
   localparam int SNAP_W    = INSTR_W + STATE_W + NUM_REGS*REG_W + FLAG_W;
   localparam int ENTRY_W   = CYC_W + SNAP_W;

   typedef enum int {M_IDLE, M_ARMED, M_POST, M_DONE, M_RD} mode_t;

   logic                      clock = 1'b0;
   logic                      reset_n = 1'b0;
   logic                      capture_en = 1'b0;
   logic [INSTR_W-1:0]        instr = '0;
   logic [STATE_W-1:0]        state_in = '0;
   logic [NUM_REGS*REG_W-1:0] regs = '0;
   logic [FLAG_W-1:0]         flags = '0;
   logic                      arm = 1'b0;
   logic                      trig_en = 1'b0;
   logic [INSTR_W-1:0]        trig_instr = 5'h13;
   logic [STATE_W-1:0]        trig_state = 5'h0A;
   logic                      busy, done, wrapped;

   i281_trace_buffer_if #(.ENTRY_W(ENTRY_W)) rd_if ();

   i281_trace_buffer #(
      .DEPTH(DEPTH), .NUM_REGS(NUM_REGS), .REG_W(REG_W), .INSTR_W(INSTR_W),
      .STATE_W(STATE_W), .FLAG_W(FLAG_W), .CYC_W(CYC_W), .POST_TRIG(POST_TRIG)
   ) dut (
      .clock(clock), .reset_n(reset_n), .capture_en(capture_en),
      .instr(instr), .state(state_in), .regs(regs), .flags(flags),
      .arm(arm), .trig_en(trig_en), .trig_instr(trig_instr), .trig_state(trig_state),
      .busy(busy), .done(done), .wrapped(wrapped), .rd(rd_if)
   );

   always #5 clock = ~clock;

   int n_cmp = 0;
   int n_err = 0;

   // model: what has been recorded since the last arm, in write order
   mode_t              m_mode = M_IDLE;
   int                 m_cyc = 0;
   int                 m_post = 0;
   int                 m_total = 0;
   bit                 m_first = 1'b1;
   logic [SNAP_W-1:0]  m_last = '0;
   logic [ENTRY_W-1:0] m_log[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic model_update();
      logic [SNAP_W-1:0] snap;
      bit hit, wr;
      snap = {instr, state_in, regs, flags};
      if (arm) begin
         m_mode = M_ARMED; m_cyc = 0; m_total = 0; m_first = 1'b1; m_log.delete();
      end else if (m_mode == M_ARMED || m_mode == M_POST) begin
         hit = (m_mode == M_ARMED) && capture_en && trig_en &&
               (instr == trig_instr) && (state_in == trig_state);
         wr = capture_en;
`ifdef I281_TRACE_DELTA_EN
         if (wr && !m_first && !hit && snap == m_last) wr = 1'b0;
`endif
         if (wr) begin
            m_log.push_back({CYC_W'(m_cyc), snap});
            m_total++; m_first = 1'b0; m_last = snap;
         end
         m_cyc++;
         if (hit) begin
            m_post = POST_TRIG;
            m_mode = (POST_TRIG == 0) ? M_DONE : M_POST;
         end else if (m_mode == M_POST && wr) begin
            m_post--;
            if (m_post == 0) m_mode = M_DONE;
         end
      end else if (m_mode == M_DONE && rd_if.rd_start) begin
         m_mode = (m_log.size() == 0) ? M_IDLE : M_RD;
      end
   endtask

   task automatic tick();
      model_update();
      @(posedge clock);
      #1;
      chk("busy", busy, m_mode == M_ARMED || m_mode == M_POST);
      chk("done", done, m_mode == M_DONE);
      chk("wrapped", wrapped, m_total > DEPTH);
      if (m_mode != M_RD) chk("rd_valid_idle", rd_if.rd_valid, 1'b0);
   endtask

   // new random snapshot (sometimes held); hit forces the trigger match, otherwise avoided
   task automatic drive(input bit hit);
      if ($urandom_range(3, 0) != 0) begin
         instr    = INSTR_W'($urandom);
         state_in = STATE_W'($urandom);
         regs     = $urandom;
         flags    = FLAG_W'($urandom);
      end
      if (hit) begin
         instr = trig_instr; state_in = trig_state;
      end else begin
         while (instr == trig_instr && state_in == trig_state) state_in = STATE_W'($urandom);
      end
   endtask

   task automatic run_to_done();
      for (int k = 0; k < 400 && m_mode != M_DONE; k++) begin
         drive(1'b0); tick();
      end
      chk("reach_done", done, 1'b1);
   endtask

   // ready_mode: 0 always ready, 1 toggling 1/0, 2 random
   task automatic readout(input int ready_mode);
      int n, base, idx;
      bit holding, rdy;
      logic [ENTRY_W-1:0] held;
      n    = (m_log.size() > DEPTH) ? DEPTH : m_log.size();
      base = m_log.size() - n;
      rd_if.rd_start = 1'b1; tick(); rd_if.rd_start = 1'b0;
      chk("rd_valid_latency", rd_if.rd_valid, 1'b1);
      idx = 0; holding = 1'b0; held = '0;
      for (int b = 0; b < 4*DEPTH + 8 && idx < n; b++) begin
         if (holding) begin
            chk("rd_hold_valid", rd_if.rd_valid, 1'b1);
            chk("rd_hold_data", rd_if.rd_data, held);
         end
         case (ready_mode)
            0:       rdy = 1'b1;
            1:       rdy = (b % 2) == 0;
            default: rdy = $urandom_range(1, 0) == 1;
         endcase
         rd_if.rd_ready = rdy;
         if (rd_if.rd_valid) begin
            chk("rd_last", rd_if.rd_last, idx == n - 1);
            if (rdy) begin
               chk("rd_data", rd_if.rd_data, m_log[base + idx]);
               idx++; holding = 1'b0;
            end else begin
               held = rd_if.rd_data; holding = 1'b1;
            end
         end
         tick();
      end
      rd_if.rd_ready = 1'b0;
      chk("rd_count", idx, n);
      m_mode = M_IDLE;
      chk("rd_valid_after", rd_if.rd_valid, 1'b0);
   endtask

   initial begin
      rd_if.rd_start = 1'b0;
      rd_if.rd_ready = 1'b0;

      // reset values
      repeat (2) @(posedge clock);
      #1;
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_wrapped", wrapped, 1'b0);
      chk("rst_rd_valid", rd_if.rd_valid, 1'b0);
      chk("rst_rd_last", rd_if.rd_last, 1'b0);
      chk("rst_rd_data", rd_if.rd_data, '0);
      reset_n = 1'b1;
      tick();

      // basic capture: 10 cycles, trigger at stamp 10, 8 post entries -> stamps 0..18
      trig_en = 1'b1; capture_en = 1'b1;
      arm = 1'b1; drive(1'b0); tick(); arm = 1'b0;
      repeat (10) begin drive(1'b0); tick(); end
      drive(1'b1); tick();
      run_to_done();
      chk("basic_fill", m_log.size() == 19 && !wrapped, 1'b1);
      readout(0);

      // wrap: trigger at stamp 100 -> 64 entries, stamps 45..108; toggling backpressure
      arm = 1'b1; drive(1'b0); tick(); arm = 1'b0;
      repeat (100) begin drive(1'b0); tick(); end
      drive(1'b1); tick();
      run_to_done();
      chk("wrap_flag", wrapped, 1'b1);
      readout(1);

      // arm during a readout beats the handshake
      arm = 1'b1; drive(1'b0); tick(); arm = 1'b0;
      repeat (5) begin drive(1'b0); tick(); end
      drive(1'b1); tick();
      run_to_done();
      rd_if.rd_start = 1'b1; tick(); rd_if.rd_start = 1'b0;
      rd_if.rd_ready = 1'b1;
      repeat (3) tick();
      arm = 1'b1; drive(1'b1); tick(); arm = 1'b0;
      rd_if.rd_ready = 1'b0;
      chk("arm_over_rd", rd_if.rd_valid, 1'b0);

      // that arm coincided with a trigger match: must stay ARMED past POST_TRIG cycles
      repeat (POST_TRIG + 2) begin drive(1'b0); tick(); end

      // capture_en gap of 3 cycles in POST
      drive(1'b1); tick();
      repeat (2) begin drive(1'b0); tick(); end
      capture_en = 1'b0;
      repeat (3) begin drive(1'b0); tick(); end
      capture_en = 1'b1;
      run_to_done();
      readout(2);

      // free-running recorder with random capture_en, rd_start ignored while armed
      trig_en = 1'b0;
      arm = 1'b1; drive(1'b0); tick(); arm = 1'b0;
      for (int k = 0; k < 150; k++) begin
         capture_en = $urandom_range(3, 0) != 0;
         drive(1'b0);
         rd_if.rd_start = (k == 70);
         tick();
      end
      rd_if.rd_start = 1'b0;
      trig_en = 1'b1; capture_en = 1'b1;
      drive(1'b1); tick();
      run_to_done();
      readout(2);

      // constant inputs for 20 cycles, then trigger on the same snapshot
      trig_en = 1'b0;
      instr = trig_instr; state_in = trig_state; regs = 32'h1234_5678; flags = 4'h5;
      arm = 1'b1; tick(); arm = 1'b0;
      repeat (20) tick();
      trig_en = 1'b1; tick();
      run_to_done();
      readout(0);

      // asynchronous reset in the middle of POST
      arm = 1'b1; drive(1'b0); tick(); arm = 1'b0;
      repeat (3) begin drive(1'b0); tick(); end
      drive(1'b1); tick();
      repeat (2) begin drive(1'b0); tick(); end
      chk("pre_reset_busy", busy, 1'b1);
      #2 reset_n = 1'b0;
      #1;
      m_mode = M_IDLE; m_total = 0; m_log.delete();
      chk("async_rst_busy", busy, 1'b0);
      chk("async_rst_done", done, 1'b0);
      chk("async_rst_rd_valid", rd_if.rd_valid, 1'b0);
      chk("async_rst_rd_data", rd_if.rd_data, '0);
      @(posedge clock); #1;
      reset_n = 1'b1;
      rd_if.rd_start = 1'b1; tick(); rd_if.rd_start = 1'b0;
      repeat (3) tick();

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
